// File: rtl/tpu_tile_ctrl.sv
// tpu_tile_ctrl
// Tiling controller for an SA_DIM x SA_DIM systolic array. Computes C = A x B
// for arbitrary K, M, N by walking output tiles (N-tile outer, M-tile inner)
// and, per tile, K-chunks of depth SA_DIM. Each chunk loads the local A/B
// buffers from the operand SRAMs (with lane and k-step zero padding), runs the
// array, and folds the partial tile into on-chip accumulators. Only valid rows
// of each finished tile are written to the result SRAM.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, K, M, N   job start strobe and matrix dimensions (A: MxK, B: KxN)
//   busy, done          job in progress / one-cycle completion pulse
//   a_addr, b_addr      operand SRAM read addresses (1-cycle read latency)
//   a_rdata, b_rdata    operand read data, lane l = A row l / B column l
//   lbuf_a, lbuf_b      local buffers, slot i = k-step i of the current chunk
//   sa_run, sa_done     array enable / array result-valid pulse
//   sa_result           partial product tile, row-major
//   c_wr_en, c_addr,    registered result SRAM write port, one tile row
//   c_wdata             per write
module tpu_tile_ctrl #(
    parameter int SA_DIM    = 4,
    parameter int DATA_BITS = 8,
    parameter int ACC_BITS  = 32,
    parameter int ADDR_BITS = 16,
    parameter int DIM_BITS  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    input  logic [DIM_BITS-1:0]                 K,
    input  logic [DIM_BITS-1:0]                 M,
    input  logic [DIM_BITS-1:0]                 N,
    output logic                                busy,
    output logic                                done,
    output logic [ADDR_BITS-1:0]                a_addr,
    output logic [ADDR_BITS-1:0]                b_addr,
    input  logic [SA_DIM*DATA_BITS-1:0]         a_rdata,
    input  logic [SA_DIM*DATA_BITS-1:0]         b_rdata,
    output logic [SA_DIM*SA_DIM*DATA_BITS-1:0]  lbuf_a,
    output logic [SA_DIM*SA_DIM*DATA_BITS-1:0]  lbuf_b,
    output logic                                sa_run,
    input  logic                                sa_done,
    input  logic [SA_DIM*SA_DIM*ACC_BITS-1:0]   sa_result,
    output logic                                c_wr_en,
    output logic [ADDR_BITS-1:0]                c_addr,
    output logic [SA_DIM*ACC_BITS-1:0]          c_wdata
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_ACC   = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_NEXT  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    localparam int STEP_BITS = $clog2(SA_DIM + 1);
    localparam int ROW_BITS  = (SA_DIM > 1) ? $clog2(SA_DIM) : 1;
    localparam int BW        = DIM_BITS + 1;   // headroom for base + SA_DIM
    localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(SA_DIM);
    localparam logic [STEP_BITS-1:0] LAST_ROW  = STEP_BITS'(SA_DIM - 1);
    localparam logic [BW-1:0]        SA_DIM_W  = BW'(SA_DIM);

    logic [2:0]           state_reg;
    logic [STEP_BITS-1:0] step_reg;        // LOAD step, reused as WRITE row
    logic [DIM_BITS-1:0]  k_dim_reg, m_dim_reg, n_dim_reg;
    // Element offsets of the current tile/chunk (index * SA_DIM), kept instead
    // of indices so bounds checks need no multipliers.
    logic [BW-1:0]        k_base_reg, m_base_reg, n_base_reg;
    // Running mt*K, nt*K and nt*Mt+mt (tile order makes the last a plain count).
    logic [ADDR_BITS-1:0] a_base_reg, b_base_reg, tile_reg;
    logic                 c_wr_en_reg;
    logic [ADDR_BITS-1:0] c_addr_reg;
    logic [SA_DIM*ACC_BITS-1:0] c_wdata_reg;

    logic [DATA_BITS-1:0] buf_a_reg [SA_DIM][SA_DIM];   // [slot][lane]
    logic [DATA_BITS-1:0] buf_b_reg [SA_DIM][SA_DIM];
    logic [ACC_BITS-1:0]  acc_reg   [SA_DIM][SA_DIM];   // [row][col]

    logic [BW-1:0]        k_dim_w, m_dim_w, n_dim_w, k_cur, cap_k, rows_left;
    logic                 last_kt, last_mt, last_nt, last_row, slot_ok;
    logic [SA_DIM-1:0]    a_lane_ok, b_lane_ok;
    logic [ROW_BITS-1:0]  row_idx;
    logic [SA_DIM*ACC_BITS-1:0] wdata_row;

    assign k_dim_w   = BW'(k_dim_reg);
    assign m_dim_w   = BW'(m_dim_reg);
    assign n_dim_w   = BW'(n_dim_reg);
    assign k_cur     = k_base_reg + BW'(step_reg);
    // Data arriving in step s belongs to the address issued in step s-1.
    assign cap_k     = k_cur - BW'(1);
    assign slot_ok   = cap_k < k_dim_w;
    assign rows_left = m_dim_w - m_base_reg;
    assign last_kt   = (k_base_reg + SA_DIM_W) >= k_dim_w;
    assign last_mt   = (m_base_reg + SA_DIM_W) >= m_dim_w;
    assign last_nt   = (n_base_reg + SA_DIM_W) >= n_dim_w;
    assign last_row  = ((BW'(step_reg) + BW'(1)) >= rows_left) || (step_reg == LAST_ROW);
    assign row_idx   = step_reg[ROW_BITS-1:0];

    assign busy    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done    = (state_reg == ST_DONE);
    assign sa_run  = (state_reg == ST_RUN);
    assign a_addr  = (state_reg == ST_LOAD && step_reg < LAST_STEP) ?
                     a_base_reg + ADDR_BITS'(k_cur) : '0;
    assign b_addr  = (state_reg == ST_LOAD && step_reg < LAST_STEP) ?
                     b_base_reg + ADDR_BITS'(k_cur) : '0;
    assign c_wr_en = c_wr_en_reg;
    assign c_addr  = c_addr_reg;
    assign c_wdata = c_wdata_reg;

    genvar gi, gl;
    generate
        for (gi = 0; gi < SA_DIM; gi++) begin : g_lane
            assign a_lane_ok[gi] = (m_base_reg + BW'(gi)) < m_dim_w;
            assign b_lane_ok[gi] = (n_base_reg + BW'(gi)) < n_dim_w;
            // Columns beyond N are forced to zero on the write path.
            assign wdata_row[gi*ACC_BITS +: ACC_BITS] =
                b_lane_ok[gi] ? acc_reg[row_idx][gi] : '0;
            for (gl = 0; gl < SA_DIM; gl++) begin : g_pack
                assign lbuf_a[(gi*SA_DIM+gl)*DATA_BITS +: DATA_BITS] = buf_a_reg[gi][gl];
                assign lbuf_b[(gi*SA_DIM+gl)*DATA_BITS +: DATA_BITS] = buf_b_reg[gi][gl];
            end
        end
    endgenerate

    // Control FSM and write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            step_reg    <= '0;
            k_dim_reg   <= '0;
            m_dim_reg   <= '0;
            n_dim_reg   <= '0;
            k_base_reg  <= '0;
            m_base_reg  <= '0;
            n_base_reg  <= '0;
            a_base_reg  <= '0;
            b_base_reg  <= '0;
            tile_reg    <= '0;
            c_wr_en_reg <= 1'b0;
            c_addr_reg  <= '0;
            c_wdata_reg <= '0;
        end else begin
            c_wr_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (K == '0 || M == '0 || N == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            k_dim_reg  <= K;
                            m_dim_reg  <= M;
                            n_dim_reg  <= N;
                            k_base_reg <= '0;
                            m_base_reg <= '0;
                            n_base_reg <= '0;
                            a_base_reg <= '0;
                            b_base_reg <= '0;
                            tile_reg   <= '0;
                            step_reg   <= '0;
                            state_reg  <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (step_reg == LAST_STEP) begin
                        step_reg  <= '0;
                        state_reg <= ST_RUN;
                    end else begin
                        step_reg <= step_reg + STEP_BITS'(1);
                    end
                end
                ST_RUN: begin
                    if (sa_done) state_reg <= ST_ACC;
                end
                ST_ACC: begin
                    step_reg <= '0;
                    if (last_kt) begin
                        state_reg <= ST_WRITE;
                    end else begin
                        k_base_reg <= k_base_reg + SA_DIM_W;
                        state_reg  <= ST_LOAD;
                    end
                end
                ST_WRITE: begin
                    c_wr_en_reg <= 1'b1;
                    c_addr_reg  <= tile_reg * ADDR_BITS'(SA_DIM) + ADDR_BITS'(step_reg);
                    c_wdata_reg <= wdata_row;
                    if (last_row) state_reg <= ST_NEXT;
                    else          step_reg  <= step_reg + STEP_BITS'(1);
                end
                ST_NEXT: begin
                    step_reg   <= '0;
                    k_base_reg <= '0;
                    tile_reg   <= tile_reg + ADDR_BITS'(1);
                    if (last_mt) begin
                        m_base_reg <= '0;
                        a_base_reg <= '0;
                        if (last_nt) begin
                            state_reg <= ST_DONE;
                        end else begin
                            n_base_reg <= n_base_reg + SA_DIM_W;
                            b_base_reg <= b_base_reg + ADDR_BITS'(k_dim_reg);
                            state_reg  <= ST_LOAD;
                        end
                    end else begin
                        m_base_reg <= m_base_reg + SA_DIM_W;
                        a_base_reg <= a_base_reg + ADDR_BITS'(k_dim_reg);
                        state_reg  <= ST_LOAD;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Local buffers: only written in LOAD, so they stay stable through RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SA_DIM; i++) begin
                for (int l = 0; l < SA_DIM; l++) begin
                    buf_a_reg[i][l] <= '0;
                    buf_b_reg[i][l] <= '0;
                end
            end
        end else if (state_reg == ST_LOAD) begin
            for (int i = 0; i < SA_DIM; i++) begin
                if (step_reg == STEP_BITS'(i + 1)) begin
                    for (int l = 0; l < SA_DIM; l++) begin
                        buf_a_reg[i][l] <= (slot_ok && a_lane_ok[l]) ?
                                           a_rdata[l*DATA_BITS +: DATA_BITS] : '0;
                        buf_b_reg[i][l] <= (slot_ok && b_lane_ok[l]) ?
                                           b_rdata[l*DATA_BITS +: DATA_BITS] : '0;
                    end
                end
            end
        end
    end

    // Accumulators wrap naturally at ACC_BITS; cleared between tiles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < SA_DIM; r++)
                for (int c = 0; c < SA_DIM; c++)
                    acc_reg[r][c] <= '0;
        end else if (state_reg == ST_IDLE || state_reg == ST_NEXT) begin
            for (int r = 0; r < SA_DIM; r++)
                for (int c = 0; c < SA_DIM; c++)
                    acc_reg[r][c] <= '0;
        end else if (state_reg == ST_ACC) begin
            for (int r = 0; r < SA_DIM; r++)
                for (int c = 0; c < SA_DIM; c++)
                    acc_reg[r][c] <= acc_reg[r][c] +
                                     sa_result[(r*SA_DIM+c)*ACC_BITS +: ACC_BITS];
        end
    end

endmodule
